dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-ported data memory between the core load/store path (port C)
//  and a DMA/loader master (port D). It arbitrates per cycle, muxes address, data
//  and write-enable onto the memory, and steers 1-cycle-latency read data back.
//  It drives a stall to the core PC register while core_req is pending but not granted.
// PARAMETERS
//  AW         32  address width (byte address, passed through unchanged)
//  DW         32  data width
//  MAX_BURST  4   max consecutive locked DMA grants while core waits (>=1)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous reset, active-low
//  core_req   in   1   core access request (load or store)
//  core_we    in   1   1=store, 0=load
//  core_addr  in   AW  core address
//  core_wdata in   DW  core store data
//  core_gnt   out  1   core access accepted this cycle
//  core_stall out  1   core_req & ~core_gnt; freezes PC/regfile write
//  core_rvld  out  1   core read data valid
//  core_rdata out  DW  core read data
//  dma_req    in   1   DMA access request
//  dma_lock   in   1   DMA requests to keep ownership on the next cycle
//  dma_we     in   1   1=write, 0=read
//  dma_addr   in   AW  DMA address
//  dma_wdata  in   DW  DMA write data
//  dma_gnt    out  1   DMA access accepted this cycle
//  dma_rvld   out  1   DMA read data valid
//  dma_rdata  out  DW  DMA read data
//  mem_en     out  1   memory access strobe
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, valid 1 cycle after a read mem_en
// BEHAVIOUR
//  - Reset (rst=0 at posedge): last_owner<=DMA, burst_cnt<=0, rd_pend<=0.
//    While rst=0, core_gnt, dma_gnt, mem_en and mem_we are forced to 0.
//    core_rvld and dma_rvld read 0 in the cycle after the reset edge.
//  - Grants are combinational from the requests and registered state. At most one grant per cycle.
//  - Arbitration, in priority order:
//    1) Only one requester -> grant it.
//    2) Both requesting, last_owner=DMA, dma_lock=1 and burst_cnt<MAX_BURST -> DMA.
//    3) Both requesting otherwise -> round-robin: grant the port that is not last_owner.
//  - After reset, last_owner=DMA, so the core wins the first tie.
//  - Memory mux: mem_en=core_gnt|dma_gnt. mem_we, mem_addr and mem_wdata come from the
//    granted port. With no grant, mem_we=0 and mem_addr/mem_wdata=0.
//  - Posedge updates:
//    - last_owner<=granted port; unchanged if no grant.
//    - burst_cnt<=burst_cnt+1 on a DMA grant that follows a DMA grant; 1 on a DMA grant
//      after core or idle; 0 on a core grant or an idle cycle. Saturates at MAX_BURST.
//  - Read return: a granted read (we=0) sets rd_pend<=1 with the owner tag.
//    Next cycle, <port>_rvld=1 for exactly one cycle and <port>_rdata=mem_rdata.
//    rdata is 0 when rvld=0.
//  - Writes produce no rvld. Back-to-back reads to alternating ports return in grant order.
//  - Fairness bound: a continuously asserted core_req is granted within MAX_BURST+1 cycles.
//    A continuously asserted dma_req is granted within 2 cycles.
//  - Requesters hold req/we/addr/wdata stable until gnt. Dropping req before gnt is legal
//    and leaves no side effect.
//  - Reset mid-operation: a pending read return is discarded (no rvld after the reset edge).
//    A burst lock is released.
// TESTING
//  - Reset: rst=0 two cycles with both reqs=1 -> all gnts/mem_en=0; first cycle after
//    release core_gnt=1.
//  - Lone core load addr=0x40, mem_rdata=0xDEADBEEF next cycle -> core_gnt=1, mem_we=0;
//    +1 cycle core_rvld=1, core_rdata=0xDEADBEEF, dma_rvld=0.
//  - Both reqs steady, dma_lock=0 -> grants alternate C,D,C,D; core_stall=1 on D cycles.
//  - DMA owner, dma_lock=1, core_req=1, MAX_BURST=4 -> 4 consecutive dma_gnt, then core_gnt;
//    core_stall=1 for exactly those 4 cycles.
//  - Core store addr=0x10 wdata=0x5A then DMA read of 0x10 -> mem_we=1 with 0x5A, then
//    dma_rvld=1 with returned data; no core_rvld.
//  - DMA read granted, rst=0 the next edge -> no dma_rvld afterwards; burst_cnt=0;
//    core wins first tie.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Per-cycle arbiter sharing one single-ported data memory between the core
// load/store path and a DMA master, with 1-cycle read-data steering.
//
// last_owner | meaning
// OWN_CORE   | core held the memory on its most recent grant
// OWN_DMA    | DMA held the memory on its most recent grant (reset value)
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvld,
  output logic [DW-1:0] core_rdata,
  input  logic          dma_req,
  input  logic          dma_lock,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvld,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_e;

  owner_e         last_owner;
  owner_e         rd_owner;
  logic [BCW-1:0] burst_cnt;
  logic           rd_pend;
  logic           lock_ok;

  // A locked DMA keeps the memory on a tie only while its burst budget lasts.
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    lock_ok  = (last_owner == OWN_DMA) && dma_lock && (burst_cnt < BCW'(MAX_BURST));
    if (rst) begin
      if (core_req && !dma_req) begin
        core_gnt = 1'b1;
      end else if (dma_req && !core_req) begin
        dma_gnt = 1'b1;
      end else if (core_req && dma_req) begin
        if (lock_ok || (last_owner == OWN_CORE)) dma_gnt = 1'b1;
        else                                     core_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = core_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  assign core_stall = core_req & ~core_gnt;
  assign core_rvld  = rd_pend && (rd_owner == OWN_CORE);
  assign dma_rvld   = rd_pend && (rd_owner == OWN_DMA);
  assign core_rdata = core_rvld ? mem_rdata : '0;
  assign dma_rdata  = dma_rvld  ? mem_rdata : '0;

  // burst_cnt is nonzero only when the previous cycle was a DMA grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_owner <= OWN_DMA;
      burst_cnt  <= '0;
      rd_pend    <= 1'b0;
      rd_owner   <= OWN_DMA;
    end else begin
      if (core_gnt)     last_owner <= OWN_CORE;
      else if (dma_gnt) last_owner <= OWN_DMA;

      if (!dma_gnt)                            burst_cnt <= '0;
      else if (burst_cnt != BCW'(MAX_BURST))   burst_cnt <= burst_cnt + 1'b1;

      rd_pend <= mem_en & ~mem_we;
      if (mem_en) rd_owner <= dma_gnt ? OWN_DMA : OWN_CORE;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a behavioural arbitration and memory model.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_we, core_gnt, core_stall, core_rvld;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          dma_req, dma_lock, dma_we, dma_gnt, dma_rvld;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvld(core_rvld), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvld(dma_rvld), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory attached to the DUT's memory port.
  bit [DW-1:0] tb_mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr[9:2]];
    end
  end

  // Behavioural model: owner of the last grant, length of the current run of
  // back-to-back DMA grants, an expected read return and a shadow memory.
  bit [DW-1:0] sh_mem [256];
  int          m_last = 1;          // 0 = core, 1 = DMA
  int          m_run  = 0;
  bit          m_pend = 1'b0;
  int          m_pend_port = 0;
  bit [DW-1:0] m_pend_data = '0;
  bit          exp_cg = 1'b0, exp_dg = 1'b0;
  bit          cg, dg;
  bit          e_we;
  bit [AW-1:0] e_addr;
  bit [DW-1:0] e_wdata;
  int          core_wait = 0, dma_wait = 0;

  always @(negedge clk) begin
    cg = 1'b0;
    dg = 1'b0;
    if (rst === 1'b1) begin
      if (core_req && !dma_req)      cg = 1'b1;
      else if (dma_req && !core_req) dg = 1'b1;
      else if (core_req && dma_req) begin
        if (m_last == 1 && dma_lock && m_run < MB) dg = 1'b1;
        else if (m_last == 1)                      cg = 1'b1;
        else                                       dg = 1'b1;
      end
    end
    e_we    = cg ? core_we    : (dg ? dma_we    : 1'b0);
    e_addr  = cg ? core_addr  : (dg ? dma_addr  : '0);
    e_wdata = cg ? core_wdata : (dg ? dma_wdata : '0);

    check("core_gnt",   core_gnt,   cg);
    check("dma_gnt",    dma_gnt,    dg);
    check("mem_en",     mem_en,     cg | dg);
    check("mem_we",     mem_we,     e_we);
    check("mem_addr",   mem_addr,   e_addr);
    check("mem_wdata",  mem_wdata,  e_wdata);
    check("core_stall", core_stall, core_req && !cg);
    check("core_rvld",  core_rvld,  m_pend && m_pend_port == 0);
    check("dma_rvld",   dma_rvld,   m_pend && m_pend_port == 1);
    check("core_rdata", core_rdata, (m_pend && m_pend_port == 0) ? m_pend_data : '0);
    check("dma_rdata",  dma_rdata,  (m_pend && m_pend_port == 1) ? m_pend_data : '0);

    // Fairness observed on the DUT's own grants.
    if (rst && core_req) begin
      if (core_gnt) check("core_wait_bound", core_wait <= MB, 1'b1);
      core_wait = core_gnt ? 0 : core_wait + 1;
    end else core_wait = 0;
    if (rst && dma_req) begin
      if (dma_gnt) check("dma_wait_bound", dma_wait <= 1, 1'b1);
      dma_wait = dma_gnt ? 0 : dma_wait + 1;
    end else dma_wait = 0;

    m_pend = 1'b0;
    if (rst !== 1'b1) begin
      m_last = 1;
      m_run  = 0;
    end else if (cg || dg) begin
      m_last = dg ? 1 : 0;
      m_run  = dg ? m_run + 1 : 0;
      if (e_we) sh_mem[e_addr[9:2]] = e_wdata;
      else begin
        m_pend      = 1'b1;
        m_pend_port = dg ? 1 : 0;
        m_pend_data = sh_mem[e_addr[9:2]];
      end
    end else m_run = 0;
    exp_cg = cg;
    exp_dg = dg;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; core_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b0;
    core_we = 1'b0; dma_we = 1'b0; core_addr = '0; dma_addr = '0;
    core_wdata = '0; dma_wdata = '0;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_core_gnt", core_gnt, 1'b0);
      check("rst_dma_gnt",  dma_gnt,  1'b0);
      check("rst_mem_en",   mem_en,   1'b0);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    check("first_tie_core", core_gnt, 1'b1);
    tick();
    core_req = 1'b0; dma_req = 1'b0;

    // DMA stores 0xDEADBEEF at 0x40, then a lone core load reads it back.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("lone_dma_gnt", dma_gnt, 1'b1);
    tick();
    dma_req = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    @(negedge clk);
    check("load_core_gnt", core_gnt, 1'b1);
    check("load_mem_we",   mem_we,   1'b0);
    tick();
    core_req = 1'b0;
    @(negedge clk);
    check("load_core_rvld",  core_rvld,  1'b1);
    check("load_core_rdata", core_rdata, 32'hDEADBEEF);
    check("load_dma_rvld",   dma_rvld,   1'b0);
    tick();

    // Make DMA the last owner, then both request steadily without lock.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'h1;
    tick();
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h84; core_wdata = 32'h2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("alt_core_gnt", core_gnt,   (i % 2) == 0);
      check("alt_stall",    core_stall, (i % 2) == 1);
      tick();
    end

    // Idle cycle clears the run; DMA stays last owner. Then a locked burst.
    core_req = 1'b0; dma_req = 1'b0;
    tick();
    core_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("burst_dma_gnt", dma_gnt,    i < 4);
      check("burst_stall",   core_stall, i < 4);
      tick();
    end

    // Core store of 0x5A to 0x10, then DMA read of 0x10.
    dma_req = 1'b0; dma_lock = 1'b0;
    core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'h5A;
    @(negedge clk);
    check("store_mem_we",    mem_we,    1'b1);
    check("store_mem_addr",  mem_addr,  32'h10);
    check("store_mem_wdata", mem_wdata, 32'h5A);
    tick();
    core_req = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
    @(negedge clk);
    check("dmard_gnt", dma_gnt, 1'b1);
    tick();
    dma_req = 1'b0;
    @(negedge clk);
    check("dmard_rvld",      dma_rvld,  1'b1);
    check("dmard_rdata",     dma_rdata, 32'h5A);
    check("dmard_core_rvld", core_rvld, 1'b0);
    tick();

    // DMA read granted, reset on the following edge discards nothing visible after it.
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
    @(negedge clk);
    check("rstrd_gnt", dma_gnt, 1'b1);
    tick();
    rst = 1'b0; dma_req = 1'b0;
    tick();
    @(negedge clk);
    check("rstrd_no_rvld", dma_rvld, 1'b0);
    tick();
    rst = 1'b1; core_req = 1'b1; dma_req = 1'b1; core_we = 1'b1; dma_we = 1'b1;
    @(negedge clk);
    check("rst2_tie_core", core_gnt, 1'b1);
    tick();
    core_req = 1'b0;
    @(negedge clk);
    check("rst2_then_dma", dma_gnt, 1'b1);
    tick();
    dma_req = 1'b0;

    // Randomized traffic; requests are held until granted or abandoned.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      if (core_req && !exp_cg) begin
        if ($urandom_range(0, 9) == 0) core_req = 1'b0;
      end else begin
        core_req   = $urandom_range(0, 1) != 0;
        core_we    = $urandom_range(0, 1) != 0;
        core_addr  = 32'($urandom_range(0, 255)) << 2;
        core_wdata = $urandom;
      end
      if (dma_req && !exp_dg) begin
        if ($urandom_range(0, 9) == 0) dma_req = 1'b0;
      end else begin
        dma_req   = $urandom_range(0, 1) != 0;
        dma_we    = $urandom_range(0, 1) != 0;
        dma_addr  = 32'($urandom_range(0, 255)) << 2;
        dma_wdata = $urandom;
      end
      dma_lock = $urandom_range(0, 3) != 0;
      tick();
    end
    core_req = 1'b0; dma_req = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
